// File: rtl/tick_sched_pkg.sv
// Shared definitions for the tick scheduler: FSM state encoding, command
// priority ordering, default divisor and processed-tick counter width.
// Optional feature macro: TICK_SCHED_CNT_EN (processed base-tick counter).
package tick_sched_pkg;

    // FSM states; the numeric values are visible on the state port
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_STEP  = 2'd3
    } state_e;

    // Decoded command; a larger encoding means a higher priority
    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_RUN   = 2'd1,
        CMD_STEP  = 2'd2,
        CMD_PAUSE = 2'd3
    } cmd_e;

    localparam int DEF_DIV_VAL = 10;
    localparam int BASE_CNT_W  = 16;

    // Collapse simultaneous command pulses to one: pause > step > run
    function automatic cmd_e cmd_select(input logic pause, input logic step,
                                        input logic run);
        cmd_e c;
        if (pause) begin
            c = CMD_PAUSE;
        end else if (step) begin
            c = CMD_STEP;
        end else if (run) begin
            c = CMD_RUN;
        end else begin
            c = CMD_NONE;
        end
        return c;
    endfunction

endpackage

// File: rtl/tick_sched_chan.sv
// One scheduler channel: divisor register, modulo counter and registered
// one-cycle tick. A load restarts the channel from count 0 with the new
// divisor; if it lands on the old divisor's terminal count, the old tick
// still fires. A divisor of 0 disables the channel.
module tick_sched_chan
    import tick_sched_pkg::*;
#(
    parameter int W_DIV   = 8,
    parameter int DEF_DIV = DEF_DIV_VAL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             proc_tick,
    input  logic             load,
    input  logic [W_DIV-1:0] load_div,
    output logic             tick
);

    localparam logic [W_DIV-1:0] ZERO    = {W_DIV{1'b0}};
    localparam logic [W_DIV-1:0] ONE     = {{(W_DIV-1){1'b0}}, 1'b1};
    localparam logic [W_DIV-1:0] DEF_DIV_L = W_DIV'(DEF_DIV);

    logic [W_DIV-1:0] div_r;
    logic [W_DIV-1:0] cnt_r;
    logic             tick_r;

    logic [W_DIV-1:0] div_nxt_s;
    logic [W_DIV-1:0] cnt_nxt_s;
    logic             tick_nxt_s;
    logic             terminal_s;

    assign terminal_s = (div_r != ZERO) && (cnt_r == (div_r - ONE));

    // Next-state for counter, divisor and tick; a load overrides the count step
    always_comb begin
        div_nxt_s  = div_r;
        cnt_nxt_s  = cnt_r;
        tick_nxt_s = 1'b0;
        if (proc_tick) begin
            tick_nxt_s = terminal_s;
            if (div_r == ZERO) begin
                cnt_nxt_s = ZERO;
            end else if (terminal_s) begin
                cnt_nxt_s = ZERO;
            end else begin
                cnt_nxt_s = cnt_r + ONE;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
        if (load) begin
            div_nxt_s = load_div;
            cnt_nxt_s = ZERO;
        end else begin
            div_nxt_s = div_r;
        end
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r  <= DEF_DIV_L;
            cnt_r  <= ZERO;
            tick_r <= 1'b0;
        end else begin
            div_r  <= div_nxt_s;
            cnt_r  <= cnt_nxt_s;
            tick_r <= tick_nxt_s;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/tick_scheduler.sv
// Tick scheduler top: shares the base clock-enable ce_in among N_CH channels,
// each with its own divisor, behind a run/pause/single-step FSM. Owns the FSM
// and the single-slot configuration handshake.
// Optional feature macro: TICK_SCHED_CNT_EN -- when defined, base_cnt counts
// processed base ticks (wrapping); otherwise base_cnt is tied to zero.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int W_DIV   = 8,
    parameter int DEF_DIV = DEF_DIV_VAL
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce_in,
    input  logic                  cmd_run,
    input  logic                  cmd_pause,
    input  logic                  cmd_step,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [2:0]            cfg_ch,
    input  logic [W_DIV-1:0]      cfg_div,
    output logic [N_CH-1:0]       tick_out,
    output logic [1:0]            state,
    output logic [BASE_CNT_W-1:0] base_cnt
);

    state_e           state_r;
    cmd_e             cmd_s;
    logic             proc_tick_s;
    logic             accept_s;
    logic             apply_s;

    logic             pend_valid_r;
    logic [2:0]       pend_ch_r;
    logic [W_DIV-1:0] pend_div_r;
    logic             cfg_ready_r;

    assign cmd_s       = cmd_select(cmd_pause, cmd_step, cmd_run);
    // ce_in is qualified by the state before this cycle's transition
    assign proc_tick_s = ce_in & ((state_r == ST_RUN) | (state_r == ST_STEP));
    assign accept_s    = cfg_valid & cfg_ready_r;
    // While stopped the pending write lands immediately; while running it
    // waits for a processed tick so it aligns with the channel's time base
    assign apply_s     = pend_valid_r &
                         (proc_tick_s | (state_r == ST_IDLE) | (state_r == ST_PAUSE));

    // Run/pause/step FSM; STEP ignores commands until it has consumed one ce_in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    case (cmd_s)
                        CMD_STEP: state_r <= ST_STEP;
                        CMD_RUN:  state_r <= ST_RUN;
                        default:  state_r <= ST_IDLE;
                    endcase
                end
                ST_RUN: begin
                    case (cmd_s)
                        CMD_PAUSE: state_r <= ST_PAUSE;
                        CMD_STEP:  state_r <= ST_STEP;
                        default:   state_r <= ST_RUN;
                    endcase
                end
                ST_PAUSE: begin
                    case (cmd_s)
                        CMD_STEP: state_r <= ST_STEP;
                        CMD_RUN:  state_r <= ST_RUN;
                        default:  state_r <= ST_PAUSE;
                    endcase
                end
                ST_STEP: begin
                    if (ce_in) begin
                        state_r <= ST_PAUSE;
                    end else begin
                        state_r <= ST_STEP;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Single pending config slot; ready is low exactly while a write is pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_r <= 1'b0;
            pend_ch_r    <= 3'd0;
            pend_div_r   <= {W_DIV{1'b0}};
            cfg_ready_r  <= 1'b1;
        end else if (accept_s) begin
            pend_valid_r <= 1'b1;
            pend_ch_r    <= cfg_ch;
            pend_div_r   <= cfg_div;
            cfg_ready_r  <= 1'b0;
        end else if (apply_s) begin
            pend_valid_r <= 1'b0;
            cfg_ready_r  <= 1'b1;
        end else begin
            pend_valid_r <= pend_valid_r;
            cfg_ready_r  <= cfg_ready_r;
        end
    end

    assign cfg_ready = cfg_ready_r;
    assign state     = state_r;

    // Channel array; an out-of-range target index matches no channel and is dropped
    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        logic load_s;
        assign load_s = apply_s & (pend_ch_r == 3'(i));

        tick_sched_chan #(
            .W_DIV   (W_DIV),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .proc_tick (proc_tick_s),
            .load      (load_s),
            .load_div  (pend_div_r),
            .tick      (tick_out[i])
        );
    end

`ifdef TICK_SCHED_CNT_EN
    logic [BASE_CNT_W-1:0] base_cnt_r;

    // Processed base-tick counter, wraps at full scale
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_cnt_r <= {BASE_CNT_W{1'b0}};
        end else if (proc_tick_s) begin
            base_cnt_r <= base_cnt_r + BASE_CNT_W'(1);
        end else begin
            base_cnt_r <= base_cnt_r;
        end
    end

    assign base_cnt = base_cnt_r;
`else
    assign base_cnt = {BASE_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed self-checking bench for tick_scheduler (N_CH=4, W_DIV=8, DEF_DIV=10).
module tb_tick_scheduler;

    logic        clk;
    logic        rst_n;
    logic        ce_in;
    logic        cmd_run;
    logic        cmd_pause;
    logic        cmd_step;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_ch;
    logic [7:0]  cfg_div;
    logic [3:0]  tick_out;
    logic [1:0]  state;
    logic [15:0] base_cnt;

    int checks;
    int failures;

    tick_scheduler #(
        .N_CH    (4),
        .W_DIV   (8),
        .DEF_DIV (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce_in     (ce_in),
        .cmd_run   (cmd_run),
        .cmd_pause (cmd_pause),
        .cmd_step  (cmd_step),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .tick_out  (tick_out),
        .state     (state),
        .base_cnt  (base_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // One ce_in pulse; returns tick_out one cycle after and two cycles after
    task automatic ce_pulse(output logic [3:0] t_after, output logic [3:0] t_gap);
        ce_in = 1'b1;
        step_clk();
        ce_in = 1'b0;
        t_after = tick_out;
        step_clk();
        t_gap = tick_out;
    endtask

    task automatic send_cmd(input logic run, input logic pause, input logic step);
        cmd_run = run; cmd_pause = pause; cmd_step = step;
        step_clk();
        cmd_run = 1'b0; cmd_pause = 1'b0; cmd_step = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step_clk();
        step_clk();
        checks++;
        if (state !== 2'd0 || tick_out !== 4'b0000 || cfg_ready !== 1'b1 || base_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset: state=%0d tick=%b ready=%b base=%0d, want 0 0000 1 0",
                     state, tick_out, cfg_ready, base_cnt);
        end
        rst_n = 1'b1;
        step_clk();
    endtask

    task automatic test_run_default();
        logic [3:0] ta, tg, exp_t;
        send_cmd(1'b1, 1'b0, 1'b0);
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("FAIL run_state: got %0d want 1", state);
        end
        for (int k = 1; k <= 30; k++) begin
            ce_pulse(ta, tg);
            exp_t = (k % 10 == 0) ? 4'b1111 : 4'b0000;
            checks++;
            if (ta !== exp_t) begin
                failures++;
                $display("FAIL default_div k=%0d: got %b want %b", k, ta, exp_t);
            end
            checks++;
            if (tg !== 4'b0000) begin
                failures++;
                $display("FAIL default_width k=%0d: got %b want 0000", k, tg);
            end
        end
    endtask

    task automatic test_cfg_run();
        logic [3:0] ta, tg, exp_t;
        ce_pulse(ta, tg);
        ce_pulse(ta, tg);
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd3;
        step_clk();
        cfg_valid = 1'b0;
        step_clk();
        step_clk();
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL cfg_ready_low: got %b want 0", cfg_ready);
        end
        ce_pulse(ta, tg);
        checks++;
        if (cfg_ready !== 1'b1 || ta !== 4'b0000) begin
            failures++;
            $display("FAIL cfg_apply: ready=%b tick=%b want 1 0000", cfg_ready, ta);
        end
        for (int k = 1; k <= 17; k++) begin
            ce_pulse(ta, tg);
            exp_t = ((k % 3 == 0) ? 4'b0010 : 4'b0000) |
                    ((k == 7 || k == 17) ? 4'b1101 : 4'b0000);
            checks++;
            if (ta !== exp_t) begin
                failures++;
                $display("FAIL cfg_run_phase k=%0d: got %b want %b", k, ta, exp_t);
            end
        end
    endtask

    task automatic test_pause_step();
        logic [3:0] ta, tg;
        send_cmd(1'b0, 1'b1, 1'b0);
        checks++;
        if (state !== 2'd2) begin
            failures++;
            $display("FAIL pause_state: got %0d want 2", state);
        end
        for (int k = 1; k <= 5; k++) begin
            ce_pulse(ta, tg);
            checks++;
            if (ta !== 4'b0000 || tg !== 4'b0000) begin
                failures++;
                $display("FAIL paused_tick k=%0d: got %b/%b want 0000", k, ta, tg);
            end
        end
        send_cmd(1'b0, 1'b0, 1'b1);
        checks++;
        if (state !== 2'd3) begin
            failures++;
            $display("FAIL step_state: got %0d want 3", state);
        end
        ce_pulse(ta, tg);
        checks++;
        if (ta !== 4'b0010 || state !== 2'd2) begin
            failures++;
            $display("FAIL step_tick: tick=%b state=%0d want 0010 2", ta, state);
        end
        ce_pulse(ta, tg);
        checks++;
        if (ta !== 4'b0000 || state !== 2'd2) begin
            failures++;
            $display("FAIL after_step: tick=%b state=%0d want 0000 2", ta, state);
        end
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd3;
        step_clk();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL pause_cfg_accept: ready=%b want 0", cfg_ready);
        end
        step_clk();
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL pause_cfg_apply: ready=%b want 1", cfg_ready);
        end
    endtask

    task automatic test_cmd_same_cycle();
        logic [3:0] ta, tg, exp_t;
        send_cmd(1'b1, 1'b0, 1'b0);
        ce_pulse(ta, tg);
        ce_pulse(ta, tg);
        ce_in = 1'b1; cmd_pause = 1'b1; cmd_run = 1'b1;
        step_clk();
        ce_in = 1'b0; cmd_pause = 1'b0; cmd_run = 1'b0;
        checks++;
        if (tick_out !== 4'b0010 || state !== 2'd2) begin
            failures++;
            $display("FAIL pause_with_ce: tick=%b state=%0d want 0010 2", tick_out, state);
        end
        step_clk();
        send_cmd(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            ce_pulse(ta, tg);
            exp_t = (k == 6) ? 4'b1111 : ((k == 3) ? 4'b0010 : 4'b0000);
            checks++;
            if (ta !== exp_t) begin
                failures++;
                $display("FAIL resume_phase k=%0d: got %b want %b", k, ta, exp_t);
            end
        end
    endtask

    task automatic test_div_zero_one();
        logic [3:0] ta, tg, exp_t;
        cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd0;
        step_clk();
        cfg_valid = 1'b0;
        ce_pulse(ta, tg);
        checks++;
        if (ta !== 4'b0000 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL div0_apply: tick=%b ready=%b want 0000 1", ta, cfg_ready);
        end
        for (int k = 1; k <= 20; k++) begin
            ce_pulse(ta, tg);
            exp_t = ((k % 3 == 2) ? 4'b0010 : 4'b0000) |
                    ((k % 10 == 9) ? 4'b1001 : 4'b0000);
            checks++;
            if (ta !== exp_t) begin
                failures++;
                $display("FAIL div0_silent k=%0d: got %b want %b", k, ta, exp_t);
            end
        end
        cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd1;
        step_clk();
        cfg_valid = 1'b0;
        ce_pulse(ta, tg);
        checks++;
        if (ta !== 4'b0000) begin
            failures++;
            $display("FAIL div1_apply: got %b want 0000", ta);
        end
        for (int k = 1; k <= 5; k++) begin
            ce_pulse(ta, tg);
            exp_t = 4'b0100 | ((k % 3 == 2) ? 4'b0010 : 4'b0000);
            checks++;
            if (ta !== exp_t) begin
                failures++;
                $display("FAIL div1_every k=%0d: got %b want %b", k, ta, exp_t);
            end
        end
        cfg_valid = 1'b1; cfg_ch = 3'd7; cfg_div = 8'd5;
        step_clk();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL badch_accept: ready=%b want 0", cfg_ready);
        end
        ce_pulse(ta, tg);
        checks++;
        if (cfg_ready !== 1'b1 || ta !== 4'b0100) begin
            failures++;
            $display("FAIL badch_apply: ready=%b tick=%b want 1 0100", cfg_ready, ta);
        end
        for (int k = 1; k <= 3; k++) begin
            ce_pulse(ta, tg);
            exp_t = (k == 2) ? 4'b1111 : 4'b0100;
            checks++;
            if (ta !== exp_t) begin
                failures++;
                $display("FAIL badch_nochange k=%0d: got %b want %b", k, ta, exp_t);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] ta, tg, exp_t;
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd4; ce_in = 1'b1;
        step_clk();
        cfg_valid = 1'b0; ce_in = 1'b0;
        checks++;
        if (tick_out !== 4'b0100 || cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL pre_reset: tick=%b ready=%b want 0100 0", tick_out, cfg_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || tick_out !== 4'b0000 || cfg_ready !== 1'b1 || base_cnt !== 16'd0) begin
            failures++;
            $display("FAIL mid_reset: state=%0d tick=%b ready=%b base=%0d want 0 0000 1 0",
                     state, tick_out, cfg_ready, base_cnt);
        end
        step_clk();
        rst_n = 1'b1;
        step_clk();
        checks++;
        if (state !== 2'd0) begin
            failures++;
            $display("FAIL post_reset_idle: got %0d want 0", state);
        end
        send_cmd(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            ce_pulse(ta, tg);
            exp_t = (k == 10) ? 4'b1111 : 4'b0000;
            checks++;
            if (ta !== exp_t) begin
                failures++;
                $display("FAIL reset_defaults k=%0d: got %b want %b", k, ta, exp_t);
            end
        end
    endtask

    task automatic test_base_cnt();
`ifdef TICK_SCHED_CNT_EN
        checks++;
        if (base_cnt !== 16'd10) begin
            failures++;
            $display("FAIL base_cnt_count: got %0d want 10", base_cnt);
        end
        rst_n = 1'b0;
        step_clk();
        rst_n = 1'b1;
        step_clk();
        send_cmd(1'b1, 1'b0, 1'b0);
        ce_in = 1'b1;
        for (int k = 0; k < 65537; k++) begin
            step_clk();
        end
        ce_in = 1'b0;
        step_clk();
        checks++;
        if (base_cnt !== 16'd1) begin
            failures++;
            $display("FAIL base_cnt_wrap: got %0d want 1", base_cnt);
        end
`else
        checks++;
        if (base_cnt !== 16'd0) begin
            failures++;
            $display("FAIL base_cnt_tied: got %0d want 0", base_cnt);
        end
`endif
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        ce_in     = 1'b0;
        cmd_run   = 1'b0;
        cmd_pause = 1'b0;
        cmd_step  = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 3'd0;
        cfg_div   = 8'd0;
        test_reset();
        test_run_default();
        test_cfg_run();
        test_pause_step();
        test_cmd_same_cycle();
        test_div_zero_one();
        test_reset_mid();
        test_base_cnt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
